// File: rtl/sample_playback_ctrl_if.sv
// sample_playback_ctrl_if: flash Avalon-MM read port, codec write handshake and playback controls.
interface sample_playback_ctrl_if #(parameter int ADDR_W = 23);
  logic [1:0]        mode;
  logic              pause;
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic              flash_mem_waitrequest;
  logic [31:0]       flash_mem_readdata;
  logic              flash_mem_readdatavalid;
  logic              write_ready;
  logic              write_s;
  logic [15:0]       writedata_left;
  logic [15:0]       writedata_right;
  logic              wrapped;
  modport master (
    input  mode, pause, flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid, write_ready,
    output flash_mem_read, flash_mem_address, write_s, writedata_left, writedata_right, wrapped
  );
  modport slave (
    output mode, pause, flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid, write_ready,
    input  flash_mem_read, flash_mem_address, write_s, writedata_left, writedata_right, wrapped
  );
endinterface

// File: rtl/sample_playback_ctrl.sv
// sample_playback_ctrl: loops over a flash sample image, unpacks 16-bit mono samples,
// applies speed mode and volume shift, and hands each sample to both codec FIFOs.
module sample_playback_ctrl #(
  parameter int NUM_WORDS = 1048576,
  parameter int ADDR_W    = 23,
  parameter int VOL_SHIFT = 6
) (
  input logic clk,
  input logic resetb,
  sample_playback_ctrl_if.master bus
);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] FETCH      = 3'd1;
  localparam logic [2:0] WAIT_DATA  = 3'd2;
  localparam logic [2:0] WAIT_READY = 3'd3;
  localparam logic [2:0] WAIT_ACK   = 3'd4;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
  logic [2:0]  state;
  logic [1:0]  mode_q;
  logic [1:0]  k;
  logic [31:0] word;
  logic [15:0] data;
  logic [15:0] sample;
  logic [15:0] vol;
  logic [2:0]  sends;
  logic        last_send;
  always_comb begin
    sends     = mode_q == 2'b01 ? 3'd1 : mode_q == 2'b10 ? 3'd4 : 3'd2;
    sample    = (mode_q == 2'b10 ? k[1] : k[0]) ? word[31:16] : word[15:0];
    vol       = 16'($signed(sample) >>> VOL_SHIFT);
    last_send = ({1'b0, k} + 3'd1) >= sends;
  end
  assign bus.writedata_left  = data;
  assign bus.writedata_right = data;
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state                 <= IDLE;
      bus.flash_mem_read    <= 1'b0;
      bus.flash_mem_address <= '0;
      bus.write_s           <= 1'b0;
      bus.wrapped           <= 1'b0;
      data                  <= '0;
      word                  <= '0;
      mode_q                <= '0;
      k                     <= '0;
    end else begin
      bus.wrapped <= 1'b0;
      case (state)
        IDLE: begin
          state              <= FETCH;
          bus.flash_mem_read <= 1'b1;
        end
        FETCH: if (!bus.flash_mem_waitrequest) begin
          state              <= WAIT_DATA;
          bus.flash_mem_read <= 1'b0;
          mode_q             <= bus.mode;
        end
        WAIT_DATA: if (bus.flash_mem_readdatavalid) begin
          word  <= bus.flash_mem_readdata;
          k     <= '0;
          state <= WAIT_READY;
        end
        WAIT_READY: if (bus.write_ready && !bus.pause) begin
          bus.write_s <= 1'b1;
          data        <= vol;
          state       <= WAIT_ACK;
        end
        WAIT_ACK: if (!bus.write_ready) begin
          bus.write_s <= 1'b0;
          if (!last_send) begin
            k     <= k + 2'd1;
            state <= WAIT_READY;
          end else begin
            // last send of this word: step to the next word, wrapping at the image end
            bus.flash_mem_address <= bus.flash_mem_address == LAST ? '0 : bus.flash_mem_address + 1'b1;
            bus.wrapped           <= bus.flash_mem_address == LAST;
            bus.flash_mem_read    <= 1'b1;
            state                 <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sample_playback_ctrl.sv
// tb_sample_playback_ctrl: directed phases with randomized flash data, stalls and codec gaps,
// checked against a sample-list reference model of the playback rules.
module tb_sample_playback_ctrl;
  localparam int NW = 4;
  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;
  sample_playback_ctrl_if #(.ADDR_W(23)) bus();
  sample_playback_ctrl #(.NUM_WORDS(NW), .ADDR_W(23), .VOL_SHIFT(6)) dut (
    .clk(clk), .resetb(resetb), .bus(bus)
  );
  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] mem [NW];
  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  logic [22:0] addrs[$];
  int nwrap = 0;
  int stall = 0;
  int lat = 0;
  bit stress = 1'b0;
  logic prev_ws, prev_ready, prev_pause, prev_wrapped;
  logic [15:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // floor division by 64 written directly, independent of any shift operator
  function automatic logic [15:0] att(input logic [15:0] s);
    int v, f;
    v = int'($signed(s));
    f = v / 64;
    if (v < 0 && v % 64 != 0) f = f - 1;
    return 16'(f);
  endfunction

  task automatic build_exp(input int md, input int nwords);
    logic [15:0] lo, hi;
    exp_q.delete();
    for (int w = 0; w < nwords; w++) begin
      lo = att(mem[w % NW][15:0]);
      hi = att(mem[w % NW][31:16]);
      if (md == 1) exp_q.push_back(lo);
      else if (md == 2) begin
        exp_q.push_back(lo); exp_q.push_back(lo); exp_q.push_back(hi); exp_q.push_back(hi);
      end else begin
        exp_q.push_back(lo); exp_q.push_back(hi);
      end
    end
  endtask

  task automatic cmp_seq(input string tag, input int n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
  endtask

  task automatic wait_got(input int n);
    int t = 0;
    while (got.size() < n && t < 4000) begin
      @(posedge clk); #1; t++;
    end
    chk("write_count_reached", got.size() >= n, 1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_read", bus.flash_mem_read, 0);
    chk("rst_addr", bus.flash_mem_address, 0);
    chk("rst_write_s", bus.write_s, 0);
    chk("rst_left", bus.writedata_left, 0);
    chk("rst_right", bus.writedata_right, 0);
    chk("rst_wrapped", bus.wrapped, 0);
  endtask

  task automatic do_reset(input logic [1:0] md);
    resetb = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk_reset_outputs();
    got.delete(); addrs.delete(); nwrap = 0;
    bus.mode = md;
    resetb = 1'b1;
  endtask

  // monitor: records writes, accepted read addresses and wrap pulses
  initial begin
    prev_ws = 0; prev_ready = 0; prev_pause = 0; prev_wrapped = 0; last_data = 0;
    forever begin
      @(negedge clk);
      if (!resetb) begin
        last_data = 0; prev_ws = 0; prev_wrapped = 0;
      end else begin
        if (bus.write_s && !prev_ws) begin
          got.push_back(bus.writedata_left);
          chk("rise_needs_ready_no_pause", {prev_ready, prev_pause}, 2'b10);
          chk("right_eq_left", bus.writedata_right, bus.writedata_left);
          last_data = bus.writedata_left;
        end else chk("data_stable", bus.writedata_left, last_data);
        if (bus.flash_mem_read && !bus.flash_mem_waitrequest) addrs.push_back(bus.flash_mem_address);
        if (bus.wrapped) begin
          nwrap++;
          chk("wrap_addr", bus.flash_mem_address, 0);
          chk("wrap_width", prev_wrapped, 0);
        end
        prev_ws = bus.write_s;
        prev_wrapped = bus.wrapped;
      end
      prev_ready = bus.write_ready;
      prev_pause = bus.pause;
    end
  end

  // flash model: serial Avalon slave with programmable stall and latency
  initial begin
    int a;
    bus.flash_mem_waitrequest = 1'b1;
    bus.flash_mem_readdatavalid = 1'b0;
    bus.flash_mem_readdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.flash_mem_read === 1'b1) begin
        for (int i = 0; i < stall; i++) begin
          @(posedge clk); #1;
          if (resetb) chk("read_held_in_stall", bus.flash_mem_read, 1);
        end
        a = int'(bus.flash_mem_address);
        bus.flash_mem_waitrequest = 1'b0;
        @(posedge clk); #1;
        bus.flash_mem_waitrequest = 1'b1;
        repeat (lat) begin @(posedge clk); #1; end
        bus.flash_mem_readdata = mem[a % NW];
        bus.flash_mem_readdatavalid = 1'b1;
        @(posedge clk); #1;
        bus.flash_mem_readdatavalid = 1'b0;
      end
    end
  end

  // codec model: immediate handshake, or random ready gaps under stress
  initial begin
    bus.write_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.write_ready = stress ? ($urandom_range(0, 2) != 0) : !bus.write_s;
    end
  end

  initial begin
    int t, n1;
    logic [1:0] md;
    bus.mode = 2'b00;
    bus.pause = 1'b0;
    mem[0] = 32'h8000_4000; mem[1] = 32'h0040_FFC0; mem[2] = $urandom; mem[3] = $urandom;
    do_reset(2'b00);
    wait_got(4);
    chk("normal_s0", got[0], 16'h0100);
    chk("normal_s1", got[1], 16'hFE00);
    chk("normal_s2", got[2], 16'hFFFF);
    chk("normal_s3", got[3], 16'h0001);
    chk("normal_addr0", addrs[0], 0);
    chk("normal_addr1", addrs[1], 1);
    chk("normal_no_wrap", nwrap, 0);

    mem[0] = 32'h2000_1000; mem[1] = 32'h1234_ABCD;
    do_reset(2'b01);
    wait_got(3);
    chk("fast_s0", got[0], 16'h0040);
    chk("fast_addr1", addrs[1], 1);
    build_exp(1, 3); cmp_seq("fast", 3);

    do_reset(2'b10);
    wait_got(6);
    chk("slow_s0", got[0], 16'h0040);
    chk("slow_s1", got[1], 16'h0040);
    chk("slow_s2", got[2], 16'h0080);
    chk("slow_s3", got[3], 16'h0080);
    chk("slow_addr1", addrs[1], 1);
    build_exp(2, 2); cmp_seq("slow", 6);

    for (int w = 0; w < NW; w++) mem[w] = $urandom;
    do_reset(2'b00);
    wait_got(10);
    build_exp(0, 5); cmp_seq("wrap", 10);
    chk("wrap_addr3", addrs[3], 3);
    chk("wrap_addr4", addrs[4], 0);
    chk("wrap_count", nwrap, 1);

    stall = 5; lat = 3; stress = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < NW; w++) mem[w] = $urandom;
      md = 2'($urandom_range(0, 3));
      do_reset(md);
      wait_got(12);
      build_exp(int'(md), 12); cmp_seq($sformatf("stress_m%0d", md), 12);
    end

    stall = 0; lat = 0; stress = 1'b0;
    do_reset(2'b00);
    for (int p = 0; p < 3; p++) begin
      t = 0;
      while (bus.write_s !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
      chk("pause_saw_write", bus.write_s, 1);
      #1 bus.pause = 1'b1;
      n1 = got.size();
      repeat (20) @(posedge clk);
      #1;
      chk("no_write_while_paused", got.size(), n1);
      chk("write_s_low_while_paused", bus.write_s, 0);
      bus.pause = 1'b0;
    end
    wait_got(8);
    build_exp(0, 4); cmp_seq("pause", 8);

    lat = 6;
    do_reset(2'b00);
    t = 0;
    while (addrs.size() < 1 && t < 1000) begin @(posedge clk); #1; t++; end
    chk("reset_phase_read_accepted", addrs.size() >= 1, 1);
    @(posedge clk); #1;
    resetb = 1'b0;
    #1;
    chk_reset_outputs();
    got.delete(); addrs.delete(); nwrap = 0;
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
    wait_got(4);
    chk("after_reset_first_addr", addrs[0], 0);
    build_exp(0, 2); cmp_seq("after_reset", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
